// File: rtl/apb_reg_slave_pkg.sv
// apb_reg_slave shared definitions: register offsets,
// CTRL/STATUS bit positions and FSM state type.
package apb_reg_slave_pkg;

  localparam logic [4:0] ID_OFS      = 5'h00;
  localparam logic [4:0] CTRL_OFS    = 5'h04;
  localparam logic [4:0] STATUS_OFS  = 5'h08;
  localparam logic [4:0] ACC_CNT_OFS = 5'h0C;
  localparam logic [4:0] SCRATCH_OFS = 5'h10;

  localparam int CTRL_WAIT_LSB = 0;
  localparam int CTRL_WAIT_MSB = 3;
  localparam int CTRL_OVR_EN   = 4;
  localparam int CTRL_ERR_INJ  = 8;
  localparam logic [8:0] CTRL_MASK = 9'h11F;

  localparam int STATUS_WERR = 0;
  localparam int STATUS_RERR = 1;
  localparam int STATUS_PERR = 2;

  localparam logic [15:0] ACC_MAX = 16'hFFFF;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

endpackage

// File: rtl/apb_reg_slave_regfile.sv
// Register storage, decode, error classification, read mux.
// In: latched request + commit strobe. Out: rdata, err, wait ctrl.
module apb_reg_slave_regfile
  import apb_reg_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h80000000,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 'hA5B00001,
  parameter bit SECURE_ONLY = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_nonsec,
  input  logic                  i_commit,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_err,
  output logic [3:0]            o_wait,
  output logic                  o_wait_en
);

  logic [ADDR_WIDTH-1:0] w_ofs;
  logic [4:0]            w_reg;
  logic w_range_err, w_align_err;
  logic w_prot_err, w_inj_err;
  logic w_is_id, w_is_ctrl, w_is_stat;
  logic w_is_acc, w_is_scr;
  logic w_wr_ok;
  logic [2:0] w_set, w_clr;

  logic [8:0]            r_ctrl;
  logic [2:0]            r_status;
  logic [15:0]           r_acc_cnt;
  logic [DATA_WIDTH-1:0] r_scratch [4];

  assign w_ofs = i_addr - BASE_ADDR;
  assign w_reg = w_ofs[4:0] & 5'h1C;

  // addresses below BASE wrap to huge offsets
  assign w_range_err = |w_ofs[ADDR_WIDTH-1:5];
  assign w_align_err = |i_addr[1:0];

  assign w_is_id   = (w_reg == ID_OFS);
  assign w_is_ctrl = (w_reg == CTRL_OFS);
  assign w_is_stat = (w_reg == STATUS_OFS);
  assign w_is_acc  = (w_reg == ACC_CNT_OFS);
  assign w_is_scr  = |(w_reg & SCRATCH_OFS);

  assign w_prot_err = SECURE_ONLY && i_nonsec;
  // CTRL stays reachable so inject can be cleared
  assign w_inj_err = r_ctrl[CTRL_ERR_INJ] && !w_is_ctrl;

  assign o_err = w_range_err | w_align_err
               | w_prot_err | w_inj_err;

  assign w_wr_ok = i_commit && i_write && !o_err;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_commit && o_err) begin
      w_set[STATUS_WERR] = i_write;
      w_set[STATUS_RERR] = !i_write;
      w_set[STATUS_PERR] = w_prot_err;
    end
    if (w_wr_ok && w_is_stat)
      w_clr = i_wdata[2:0];
  end

  always_comb begin
    o_rdata = '0;
    unique case (1'b1)
      w_is_id:   o_rdata = ID_VALUE;
      w_is_ctrl: o_rdata = DATA_WIDTH'(r_ctrl);
      w_is_stat: o_rdata = DATA_WIDTH'(r_status);
      w_is_acc:  o_rdata = DATA_WIDTH'(r_acc_cnt);
      w_is_scr:  o_rdata = r_scratch[w_reg[3:2]];
      default:   o_rdata = '0;
    endcase
    if (o_err)
      o_rdata = '0;
  end

  assign o_wait    = r_ctrl[CTRL_WAIT_MSB:CTRL_WAIT_LSB];
  assign o_wait_en = r_ctrl[CTRL_OVR_EN];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ctrl    <= '0;
      r_status  <= '0;
      r_acc_cnt <= '0;
      for (int i = 0; i < 4; i++)
        r_scratch[i] <= '0;
    end else begin
      // set beats clear on the same bit
      r_status <= (r_status & ~w_clr) | w_set;
      if (i_commit && r_acc_cnt != ACC_MAX)
        r_acc_cnt <= r_acc_cnt + 16'd1;
      if (w_wr_ok && w_is_ctrl)
        r_ctrl <= i_wdata[8:0] & CTRL_MASK;
      if (w_wr_ok && w_is_scr)
        r_scratch[w_reg[3:2]] <= i_wdata;
    end
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB register slave top: setup/access FSM and wait counter.
// Ports: APB PCLK/PRESETn, PADDR..PPROT in; PRDATA/PSLVERROR/PREADY out.
module apb_reg_slave
  import apb_reg_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h80000000,
  parameter int WAIT_STATES = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 'hA5B00001,
  parameter bit SECURE_ONLY = 1'b0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PWRITE,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [2:0]            PPROT,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERROR,
  output logic                  PREADY
);

  state_e r_state, w_next;
  logic [3:0] r_cnt, w_n;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic r_write, r_nonsec;
  logic w_setup, w_done, w_err;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [3:0] w_wait;
  logic w_wait_en;
  logic w_unused_prot;

  // only the non-secure bit matters here
  assign w_unused_prot = ^{PPROT[2], PPROT[0]};

  assign w_setup = PSEL && !PENABLE;
  assign w_n = w_wait_en ? w_wait : 4'(WAIT_STATES);
  assign w_done = (r_state == ACCESS) && PSEL
               && (r_cnt == '0);

  always_comb begin
    w_next    = r_state;
    PREADY    = 1'b0;
    PSLVERROR = 1'b0;
    PRDATA    = '0;
    case (r_state)
      IDLE: begin
        if (w_setup)
          w_next = ACCESS;
      end
      ACCESS: begin
        if (!PSEL || r_cnt == '0)
          w_next = IDLE;
        PREADY    = w_done;
        PSLVERROR = w_done && w_err;
        if (w_done && !r_write)
          PRDATA = w_rdata;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_write  <= 1'b0;
      r_nonsec <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_setup) begin
        r_addr   <= PADDR;
        r_wdata  <= PWDATA;
        r_write  <= PWRITE;
        r_nonsec <= PPROT[1];
        r_cnt    <= w_n;
      end else if (r_state == ACCESS && PSEL
                   && r_cnt != '0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  apb_reg_slave_regfile #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .ID_VALUE   (ID_VALUE),
    .SECURE_ONLY(SECURE_ONLY)
  ) u_rf (
    .i_clk    (PCLK),
    .i_rst_n  (PRESETn),
    .i_addr   (r_addr),
    .i_write  (r_write),
    .i_wdata  (r_wdata),
    .i_nonsec (r_nonsec),
    .i_commit (w_done),
    .o_rdata  (w_rdata),
    .o_err    (w_err),
    .o_wait   (w_wait),
    .o_wait_en(w_wait_en)
  );

endmodule

// File: doc/apb_reg_slave.md
Name: apb_reg_slave

Overview:
APB slave peripheral that sits downstream of the xAHB2APB bridge, one instance per PSEL line on the shared APB bus. It provides a small memory-mapped register file with programmable wait-state insertion, address/alignment/security error signalling and a saturating access counter. Its outputs are zero whenever it is not completing a transfer, so several instances can be OR-combined onto the shared PRDATA/PREADY/PSLVERROR bus.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width; fixed at 32 for this block
BASE_ADDR, 32'h80000000, byte address of register 0x00
WAIT_STATES, 2, default wait states per transfer, 0..15
ID_VALUE, 32'hA5B00001, reset value and constant value of the ID register
SECURE_ONLY, 0, when 1, non-secure accesses (PPROT[1]=1) are rejected

Ports:
PCLK  in  1  APB clock
PRESETn  in  1  asynchronous active-low reset
PADDR  in  ADDR_WIDTH  byte address
PWDATA  in  DATA_WIDTH  write data
PWRITE  in  1  1 = write
PSEL  in  1  slave select
PENABLE  in  1  access phase
PPROT  in  3  [0] privileged, [1] non-secure, [2] instruction
PRDATA  out  DATA_WIDTH  read data; 0 unless PREADY=1 and read
PSLVERROR  out  1  error; valid only with PREADY=1, 0 otherwise
PREADY  out  1  transfer complete

Behaviour:
- Clock and reset: one clock, PCLK. PRESETn is asynchronous and active-low. During reset, FSM=IDLE, wait counter=0, CTRL=0, STATUS=0, ACC_CNT=0, scratch registers=0, and PRDATA/PSLVERROR/PREADY=0.
- Register map (offsets from BASE_ADDR):
  - 0x00 ID: RO, returns ID_VALUE.
  - 0x04 CTRL: RW. [3:0] wait override, [4] override enable, [8] error inject. Bits not listed read as 0.
  - 0x08 STATUS: write-1-to-clear. [0] write error, [1] read error, [2] protection error.
  - 0x0C ACC_CNT: RO. [15:0] saturating count of completed transfers.
  - 0x10-0x1C SCRATCH0-3: RW.
  - Writes to RO registers complete with no error and have no effect.
- Effective wait count: N = CTRL[4] ? CTRL[3:0] : WAIT_STATES. N is sampled at the setup edge, so a CTRL write takes effect from the next transfer.
- FSM states: IDLE, ACCESS.
  - IDLE: at a posedge with PSEL=1 and PENABLE=0, latch PADDR, PWRITE, PWDATA and PPROT, load cnt=N, then go to ACCESS. Any other input combination stays in IDLE. PENABLE without a preceding setup is ignored.
  - ACCESS with PSEL=0: abort. Go to IDLE; no commit, no count, no STATUS update.
  - ACCESS with cnt>0: PREADY=0, cnt decrements.
  - ACCESS with cnt==0: PREADY=1 combinationally from state/cnt. PRDATA and PSLVERROR are driven from the latched request. At the next edge, commit the write if there is no error, update STATUS and ACC_CNT, and go to IDLE.
- Latency: PREADY rises in access cycle N+1. With N=0 this is the first PENABLE cycle.
- Back-to-back: a new setup in the cycle after completion is accepted from IDLE normally.
- Error conditions (any one gives PSLVERROR=1, the write is suppressed and PRDATA=0):
  - offset outside 0x00-0x1F
  - PADDR[1:0] != 0
  - SECURE_ONLY=1 and PPROT[1]=1
  - CTRL[8]=1, except accesses to CTRL itself, so inject can be cleared
- STATUS update on an errored completion:
  - bit0 set for a write error, bit1 set for a read error.
  - bit2 is additionally set when the cause is protection.
- Simultaneous W1C clear and new error on the same bit: set wins.
- ACC_CNT: increments on every completed transfer, errored or not, and saturates at 16'hFFFF (no wrap).
- Reset asserted mid-transfer: everything returns to reset values immediately and no commit occurs.

Decomposition:
- Package apb_reg_slave_pkg holds:
  - register offset localparams (ID_OFS, CTRL_OFS, STATUS_OFS, ACC_CNT_OFS, SCRATCH_OFS)
  - CTRL bit-position constants
  - STATUS bit-position constants
  - the state_e enum {IDLE, ACCESS}
- Sub-module apb_reg_slave_regfile contains the storage, address decode, error classification and read mux. It takes the latched request plus a commit strobe and returns rdata and err.
- The top level keeps the FSM and the wait counter.

Test Plan:
- Write 0xDEADBEEF to 0x80000010 then read it back, with WAIT_STATES=2 -> PREADY rises on the 3rd PENABLE cycle of each transfer, PRDATA=0xDEADBEEF, PSLVERROR=0, ACC_CNT=2.
- Write 0x10 to CTRL (override enable, wait=0), then read ID -> the ID read completes in the first access cycle with PRDATA=0xA5B00001.
- Read 0x80000020, then write 0x80000011 -> both complete with PSLVERROR=1 and PRDATA=0; STATUS=0x3. Writing 0x3 to STATUS -> STATUS=0.
- SECURE_ONLY=1, write SCRATCH1 with PPROT=3'b010 -> PSLVERROR=1, SCRATCH1 unchanged, STATUS=0x5.
- PSEL dropped after 1 wait cycle of a write to SCRATCH0 -> no PREADY, SCRATCH0 unchanged, ACC_CNT unchanged. A following read of SCRATCH0 completes normally.
- Force ACC_CNT to 0xFFFE and perform 3 reads -> ACC_CNT=0xFFFF. Assert PRESETn=0 mid-access -> PREADY=0 and all registers are 0 in the same cycle.
